// File: rtl/bid_round_engine_if.sv
// Command / bidder bundle for bid_round_engine.
// bidmaster: the engine side. bidslave: the controller and bidders driving it.
interface bid_round_engine_if #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int BIDAMTBITS = DATAWIDTH/2
);
    logic [DATAWIDTH-1:0]             C_data;
    logic [3:0]                       C_op;
    logic                             C_start;
    logic [NUMBIDDERS-1:0]            bid;
    logic [NUMBIDDERS-1:0]            retract;
    logic [NUMBIDDERS*BIDAMTBITS-1:0] bidAmt;
    logic [NUMBIDDERS-1:0]            ack;
    logic [NUMBIDDERS*3-1:0]          bidErr;
    logic [NUMBIDDERS*DATAWIDTH-1:0]  balance;
    logic [NUMBIDDERS-1:0]            win;
    logic                             ready;
    logic [2:0]                       err;
    logic                             roundOver;
    logic [DATAWIDTH-1:0]             maxBid;

    modport bidmaster (
        input  C_data, C_op, C_start, bid, retract, bidAmt,
        output ack, bidErr, balance, win, ready, err, roundOver, maxBid
    );

    modport bidslave (
        output C_data, C_op, C_start, bid, retract, bidAmt,
        input  ack, bidErr, balance, win, ready, err, roundOver, maxBid
    );
endinterface

// File: rtl/bid_round_engine.sv
// N-bidder auction engine: lock/unlock controller with keyed cooldown,
// per-bidder balances, bid charges, masking and round settlement.
// Optional macro BIDS_TIEBREAK_EN: a tie for the highest bid goes to the
// lowest-index bidder; otherwise a tie settles with no winner and flags
// DUPLICATEBIDS.
module bid_round_engine #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int BIDAMTBITS = DATAWIDTH/2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bid_round_engine_if.bidmaster bus
);
    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8
    } opcodes_t;

    typedef enum logic [2:0] {
        NOERROR            = 3'd0,
        BADKEY             = 3'd1,
        ALREADYUNLOCKED    = 3'd2,
        CSTARTWHENUNLOCKED = 3'd3,
        INVALID_OP         = 3'd4,
        DUPLICATEBIDS      = 3'd5
    } outerrors_t;

    typedef enum logic [2:0] {
        NOBIDERROR        = 3'd0,
        ROUNDINACTIVE     = 3'd1,
        INSUFFICIENTFUNDS = 3'd2,
        INVALIDREQUEST    = 3'd3
    } biderrors_t;

    typedef enum logic [2:0] {
        RESET        = 3'd0,
        UNLOCKED     = 3'd1,
        LOCKED       = 3'd2,
        COOLDOWN     = 3'd3,
        ROUNDSTARTED = 3'd4,
        ROUNDOVER    = 3'd5,
        READYNEXT    = 3'd6
    } states_t;

    states_t                 state_reg;
    logic [DATAWIDTH-1:0]    key_reg;
    logic [NUMBIDDERS-1:0]   mask_reg;
    logic [DATAWIDTH-1:0]    timer_reg;
    logic [DATAWIDTH-1:0]    cnt_reg;
    logic [DATAWIDTH-1:0]    charge_reg;
    logic [2:0]              sel_reg;
    logic [DATAWIDTH-1:0]    balance_reg [NUMBIDDERS];
    logic [BIDAMTBITS-1:0]   lastbid_reg [NUMBIDDERS];
    biderrors_t              biderr_reg  [NUMBIDDERS];
    logic [NUMBIDDERS-1:0]   ack_reg;
    logic [NUMBIDDERS-1:0]   win_reg;
    logic                    ready_reg;
    outerrors_t              err_reg;
    logic                    roundover_reg;
    logic [DATAWIDTH-1:0]    maxbid_reg;

    logic [BIDAMTBITS-1:0]   amt_w   [NUMBIDDERS];
    logic [NUMBIDDERS-1:0]   short_w;
    logic [BIDAMTBITS-1:0]   best_amt;
    logic [2:0]              best_idx;
    logic [3:0]              best_cnt;
    logic                    tie_block;

    // Per-bidder slicing and the funds check (balance vs amount + charge, one extra bit).
    for (genvar gi = 0; gi < NUMBIDDERS; gi++) begin : g_bidder
        logic [DATAWIDTH:0] need;
        assign amt_w[gi]   = bus.bidAmt[gi*BIDAMTBITS +: BIDAMTBITS];
        assign need        = {1'b0, DATAWIDTH'(amt_w[gi])} + {1'b0, charge_reg};
        assign short_w[gi] = ({1'b0, balance_reg[gi]} < need);
        assign bus.balance[gi*DATAWIDTH +: DATAWIDTH] = balance_reg[gi];
        assign bus.bidErr[gi*3 +: 3]                  = biderr_reg[gi];
    end

    assign bus.ack       = ack_reg;
    assign bus.win       = win_reg;
    assign bus.ready     = ready_reg;
    assign bus.err       = err_reg;
    assign bus.roundOver = roundover_reg;
    assign bus.maxBid    = maxbid_reg;

    // Highest standing bid, lowest index holding it, and how many bidders share it.
    always_comb begin
        best_amt = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (lastbid_reg[i] > best_amt) best_amt = lastbid_reg[i];
        end
        best_idx = '0;
        best_cnt = '0;
        for (int i = NUMBIDDERS-1; i >= 0; i--) begin
            if ((best_amt != '0) && (lastbid_reg[i] == best_amt)) begin
                best_idx = 3'(i);
                best_cnt = best_cnt + 4'd1;
            end
        end
`ifdef BIDS_TIEBREAK_EN
        tie_block = 1'b0;
`else
        tie_block = (best_cnt > 4'd1);
`endif
    end

    // Controller FSM with all outputs registered; error and ack outputs are one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RESET;
            key_reg       <= '0;
            mask_reg      <= '1;
            timer_reg     <= '0;
            cnt_reg       <= '0;
            charge_reg    <= DATAWIDTH'(1);
            sel_reg       <= '0;
            ack_reg       <= '0;
            win_reg       <= '0;
            ready_reg     <= 1'b0;
            err_reg       <= NOERROR;
            roundover_reg <= 1'b0;
            maxbid_reg    <= '0;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                balance_reg[i] <= '0;
                lastbid_reg[i] <= '0;
                biderr_reg[i]  <= NOBIDERROR;
            end
        end else begin
            ack_reg       <= '0;
            err_reg       <= NOERROR;
            roundover_reg <= 1'b0;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                biderr_reg[i] <= ((state_reg != ROUNDSTARTED) && bus.bid[i]) ? ROUNDINACTIVE : NOBIDERROR;
            end

            case (state_reg)
                RESET: begin
                    state_reg <= UNLOCKED;
                    ready_reg <= 1'b1;
                end

                UNLOCKED: begin
                    if (bus.C_start) begin
                        err_reg <= CSTARTWHENUNLOCKED;
                    end else begin
                        case (bus.C_op)
                            NO_OP: ;
                            UNLOCK:       err_reg <= ALREADYUNLOCKED;
                            LOCK: begin
                                key_reg   <= bus.C_data;
                                state_reg <= LOCKED;
                            end
                            SETMASK:      mask_reg   <= bus.C_data[NUMBIDDERS-1:0];
                            SETTIMER:     timer_reg  <= bus.C_data;
                            SETBIDCHARGE: charge_reg <= bus.C_data;
                            LOADX: begin
                                if (32'(bus.C_data[2:0]) < NUMBIDDERS) sel_reg <= bus.C_data[2:0];
                                else                                   err_reg <= INVALID_OP;
                            end
                            LOADY: begin
                                for (int i = 0; i < NUMBIDDERS; i++) begin
                                    if (sel_reg == 3'(i)) balance_reg[i] <= bus.C_data;
                                end
                            end
                            default:      err_reg <= INVALID_OP;
                        endcase
                    end
                end

                LOCKED, READYNEXT: begin
                    if (bus.C_start) begin
                        state_reg  <= ROUNDSTARTED;
                        ready_reg  <= 1'b0;
                        win_reg    <= '0;
                        maxbid_reg <= '0;
                        for (int i = 0; i < NUMBIDDERS; i++) lastbid_reg[i] <= '0;
                    end else begin
                        case (bus.C_op)
                            NO_OP: ;
                            UNLOCK: begin
                                if (bus.C_data == key_reg) begin
                                    state_reg <= UNLOCKED;
                                end else begin
                                    err_reg   <= BADKEY;
                                    state_reg <= COOLDOWN;
                                    cnt_reg   <= timer_reg;
                                    ready_reg <= 1'b0;
                                end
                            end
                            default: err_reg <= INVALID_OP;
                        endcase
                    end
                end

                COOLDOWN: begin
                    if (cnt_reg == '0) begin
                        state_reg <= LOCKED;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - DATAWIDTH'(1);
                    end
                end

                ROUNDSTARTED: begin
                    for (int i = 0; i < NUMBIDDERS; i++) begin
                        if (bus.retract[i]) begin
                            ack_reg[i]     <= 1'b1;
                            lastbid_reg[i] <= '0;
                        end else if (bus.bid[i]) begin
                            if (!mask_reg[i]) begin
                                biderr_reg[i] <= INVALIDREQUEST;
                            end else if (short_w[i]) begin
                                biderr_reg[i] <= INSUFFICIENTFUNDS;
                            end else begin
                                ack_reg[i]     <= 1'b1;
                                balance_reg[i] <= balance_reg[i] - charge_reg;
                                lastbid_reg[i] <= amt_w[i];
                            end
                        end
                    end
                    if (!bus.C_start) state_reg <= ROUNDOVER;
                end

                ROUNDOVER: begin
                    roundover_reg <= 1'b1;
                    state_reg     <= READYNEXT;
                    ready_reg     <= 1'b1;
                    if (best_amt != '0) begin
                        if (tie_block) begin
                            err_reg <= DUPLICATEBIDS;
                        end else begin
                            maxbid_reg <= DATAWIDTH'(best_amt);
                            for (int i = 0; i < NUMBIDDERS; i++) begin
                                if (best_idx == 3'(i)) begin
                                    balance_reg[i] <= balance_reg[i] - DATAWIDTH'(best_amt);
                                    win_reg[i]     <= 1'b1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= RESET;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bid_round_engine.sv
// Directed bench for bid_round_engine: lock/key/cooldown, round settlement,
// funds and mask errors, ties, retracts and mid-round reset.
module tb_bid_round_engine;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int BW = 16;

    localparam logic [3:0] OP_NO     = 4'd0;
    localparam logic [3:0] OP_UNLOCK = 4'd1;
    localparam logic [3:0] OP_LOCK   = 4'd2;
    localparam logic [3:0] OP_LOADX  = 4'd3;
    localparam logic [3:0] OP_LOADY  = 4'd4;
    localparam logic [3:0] OP_MASK   = 4'd6;
    localparam logic [3:0] OP_TIMER  = 4'd7;
    localparam logic [3:0] OP_CHARGE = 4'd8;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_BADKEY  = 3'd1;
    localparam logic [2:0] E_ALREADY = 3'd2;
    localparam logic [2:0] E_CSTART  = 3'd3;
    localparam logic [2:0] E_INVOP   = 3'd4;
    localparam logic [2:0] E_DUP     = 3'd5;

    localparam logic [2:0] BE_INACT  = 3'd1;
    localparam logic [2:0] BE_FUNDS  = 3'd2;
    localparam logic [2:0] BE_INVREQ = 3'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bid_round_engine_if #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .BIDAMTBITS(BW)) bus ();

    bid_round_engine #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .BIDAMTBITS(BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [DW-1:0] data);
        bus.C_op   = op;
        bus.C_data = data;
        tick();
        bus.C_op   = OP_NO;
        bus.C_data = '0;
    endtask

    task automatic do_bid(input logic [NB-1:0] b, input logic [NB-1:0] r, input logic [BW-1:0] amt);
        bus.bid     = b;
        bus.retract = r;
        bus.bidAmt  = '0;
        for (int i = 0; i < NB; i++) if (b[i]) bus.bidAmt[i*BW +: BW] = amt;
        tick();
        bus.bid     = '0;
        bus.retract = '0;
        bus.bidAmt  = '0;
    endtask

    task automatic start_round();
        bus.C_start = 1'b1;
        tick();
    endtask

    task automatic end_round(output bit seen);
        bus.C_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (bus.roundOver === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.C_op = OP_NO; bus.C_data = '0; bus.C_start = 1'b0;
        bus.bid = '0; bus.retract = '0; bus.bidAmt = '0;
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.balance !== '0) begin errors++; $display("FAIL reset_balance got=%h exp=0", bus.balance); end
        checks++; if ({bus.win, bus.err, bus.roundOver, bus.ack} !== '0) begin errors++; $display("FAIL reset_outs got=%h exp=0", {bus.win, bus.err, bus.roundOver, bus.ack}); end
        reset_n = 1'b1;
        tick();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL unlocked_ready got=%b exp=1", bus.ready); end
        $display("test_reset done");
    endtask

    task automatic test_lock_key();
        int cnt;
        cmd(OP_UNLOCK, 32'h0);
        checks++; if (bus.err !== E_ALREADY) begin errors++; $display("FAIL already_unlocked got=%0d exp=%0d", bus.err, E_ALREADY); end
        tick();
        checks++; if (bus.err !== E_NONE) begin errors++; $display("FAIL err_pulse got=%0d exp=0", bus.err); end
        bus.C_start = 1'b1; tick(); bus.C_start = 1'b0;
        checks++; if (bus.err !== E_CSTART) begin errors++; $display("FAIL cstart_unlocked got=%0d exp=%0d", bus.err, E_CSTART); end
        cmd(OP_LOADX, 32'd5);
        checks++; if (bus.err !== E_INVOP) begin errors++; $display("FAIL loadx_range got=%0d exp=%0d", bus.err, E_INVOP); end
        cmd(OP_TIMER, 32'd3);
        cmd(OP_LOCK, 32'h55);
        checks++; if (bus.err !== E_NONE || bus.ready !== 1'b1) begin errors++; $display("FAIL lock got err=%0d ready=%b exp err=0 ready=1", bus.err, bus.ready); end
        cmd(OP_UNLOCK, 32'h54);
        checks++; if (bus.err !== E_BADKEY) begin errors++; $display("FAIL badkey got=%0d exp=%0d", bus.err, E_BADKEY); end
        cnt = (bus.ready === 1'b0) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ready === 1'b1) break;
            cnt++;
        end
        checks++; if (cnt != 4) begin errors++; $display("FAIL cooldown_len got=%0d exp=4", cnt); end
        cmd(OP_UNLOCK, 32'h55);
        checks++; if (bus.err !== E_NONE) begin errors++; $display("FAIL goodkey got=%0d exp=0", bus.err); end
        cmd(OP_UNLOCK, 32'h0);
        checks++; if (bus.err !== E_ALREADY) begin errors++; $display("FAIL relock_state got=%0d exp=%0d", bus.err, E_ALREADY); end
        $display("test_lock_key done");
    endtask

    task automatic test_round_win();
        bit seen;
        cmd(OP_LOADX, 32'd1); cmd(OP_LOADY, 32'd100);
        cmd(OP_LOADX, 32'd0); cmd(OP_LOADY, 32'd10);
        cmd(OP_CHARGE, 32'd2);
        cmd(OP_LOCK, 32'h55);
        do_bid(4'b0100, 4'b0000, 16'd7);
        checks++; if (bus.bidErr[2*3 +: 3] !== BE_INACT || bus.ack !== 4'b0000) begin errors++; $display("FAIL bid_locked got err=%0d ack=%b exp err=%0d ack=0000", bus.bidErr[6 +: 3], bus.ack, BE_INACT); end
        start_round();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL round_ready got=%b exp=0", bus.ready); end
        do_bid(4'b0001, 4'b0000, 16'd9);
        checks++; if (bus.bidErr[0 +: 3] !== BE_FUNDS || bus.ack !== 4'b0000 || bus.balance[0 +: DW] !== 32'd10) begin errors++; $display("FAIL insufficient got err=%0d ack=%b bal=%0d exp err=%0d ack=0000 bal=10", bus.bidErr[0 +: 3], bus.ack, bus.balance[0 +: DW], BE_FUNDS); end
        do_bid(4'b0001, 4'b0000, 16'd8);
        checks++; if (bus.ack !== 4'b0001 || bus.balance[0 +: DW] !== 32'd8) begin errors++; $display("FAIL exact_funds got ack=%b bal=%0d exp ack=0001 bal=8", bus.ack, bus.balance[0 +: DW]); end
        do_bid(4'b0010, 4'b0000, 16'd40);
        checks++; if (bus.ack !== 4'b0010 || bus.balance[DW +: DW] !== 32'd98) begin errors++; $display("FAIL bid1 got ack=%b bal=%0d exp ack=0010 bal=98", bus.ack, bus.balance[DW +: DW]); end
        end_round(seen);
        checks++; if (!seen) begin errors++; $display("FAIL roundover_timeout got=0 exp=1"); end
        checks++; if (bus.win !== 4'b0010 || bus.maxBid !== 32'd40) begin errors++; $display("FAIL winner got win=%b max=%0d exp win=0010 max=40", bus.win, bus.maxBid); end
        checks++; if (bus.balance[DW +: DW] !== 32'd58 || bus.balance[0 +: DW] !== 32'd8) begin errors++; $display("FAIL settle got b1=%0d b0=%0d exp b1=58 b0=8", bus.balance[DW +: DW], bus.balance[0 +: DW]); end
        tick();
        checks++; if (bus.roundOver !== 1'b0 || bus.ready !== 1'b1 || bus.win !== 4'b0010) begin errors++; $display("FAIL readynext got ro=%b ready=%b win=%b exp ro=0 ready=1 win=0010", bus.roundOver, bus.ready, bus.win); end
        $display("test_round_win done");
    endtask

    task automatic test_mask();
        bit seen;
        cmd(OP_UNLOCK, 32'h55);
        cmd(OP_MASK, 32'hE);
        cmd(OP_LOCK, 32'h55);
        start_round();
        checks++; if (bus.win !== 4'b0000 || bus.maxBid !== 32'd0) begin errors++; $display("FAIL round_clear got win=%b max=%0d exp win=0000 max=0", bus.win, bus.maxBid); end
        do_bid(4'b0001, 4'b0000, 16'd1);
        checks++; if (bus.bidErr[0 +: 3] !== BE_INVREQ || bus.ack !== 4'b0000 || bus.balance[0 +: DW] !== 32'd8) begin errors++; $display("FAIL masked got err=%0d ack=%b bal=%0d exp err=%0d ack=0000 bal=8", bus.bidErr[0 +: 3], bus.ack, bus.balance[0 +: DW], BE_INVREQ); end
        end_round(seen);
        checks++; if (!seen || bus.win !== 4'b0000 || bus.maxBid !== 32'd0) begin errors++; $display("FAIL empty_round got seen=%b win=%b max=%0d exp seen=1 win=0000 max=0", seen, bus.win, bus.maxBid); end
        $display("test_mask done");
    endtask

    task automatic test_tie();
        bit seen;
        cmd(OP_UNLOCK, 32'h55);
        cmd(OP_MASK, 32'hF);
        cmd(OP_LOADX, 32'd2); cmd(OP_LOADY, 32'd200);
        cmd(OP_LOADX, 32'd3); cmd(OP_LOADY, 32'd200);
        cmd(OP_LOCK, 32'h55);
        start_round();
        do_bid(4'b1100, 4'b0000, 16'd50);
        checks++; if (bus.ack !== 4'b1100 || bus.balance[2*DW +: DW] !== 32'd198 || bus.balance[3*DW +: DW] !== 32'd198) begin errors++; $display("FAIL tie_bids got ack=%b b2=%0d b3=%0d exp ack=1100 b2=198 b3=198", bus.ack, bus.balance[2*DW +: DW], bus.balance[3*DW +: DW]); end
        end_round(seen);
        checks++; if (!seen) begin errors++; $display("FAIL tie_roundover_timeout got=0 exp=1"); end
`ifdef BIDS_TIEBREAK_EN
        checks++; if (bus.win !== 4'b0100 || bus.maxBid !== 32'd50 || bus.err !== E_NONE) begin errors++; $display("FAIL tie_break got win=%b max=%0d err=%0d exp win=0100 max=50 err=0", bus.win, bus.maxBid, bus.err); end
        checks++; if (bus.balance[2*DW +: DW] !== 32'd148 || bus.balance[3*DW +: DW] !== 32'd198) begin errors++; $display("FAIL tie_settle got b2=%0d b3=%0d exp b2=148 b3=198", bus.balance[2*DW +: DW], bus.balance[3*DW +: DW]); end
`else
        checks++; if (bus.win !== 4'b0000 || bus.maxBid !== 32'd0 || bus.err !== E_DUP) begin errors++; $display("FAIL tie_dup got win=%b max=%0d err=%0d exp win=0000 max=0 err=%0d", bus.win, bus.maxBid, bus.err, E_DUP); end
        checks++; if (bus.balance[2*DW +: DW] !== 32'd198 || bus.balance[3*DW +: DW] !== 32'd198) begin errors++; $display("FAIL tie_settle got b2=%0d b3=%0d exp b2=198 b3=198", bus.balance[2*DW +: DW], bus.balance[3*DW +: DW]); end
`endif
        $display("test_tie done");
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [DW-1:0] exp_b2;
`ifdef BIDS_TIEBREAK_EN
        exp_b2 = 32'd148;
`else
        exp_b2 = 32'd198;
`endif
        start_round();
        do_bid(4'b1000, 4'b0000, 16'd30);
        checks++; if (bus.ack !== 4'b1000 || bus.balance[3*DW +: DW] !== 32'd196) begin errors++; $display("FAIL b2b_bid got ack=%b b3=%0d exp ack=1000 b3=196", bus.ack, bus.balance[3*DW +: DW]); end
        do_bid(4'b0000, 4'b1000, 16'd0);
        checks++; if (bus.ack !== 4'b1000 || bus.balance[3*DW +: DW] !== 32'd196) begin errors++; $display("FAIL retract got ack=%b b3=%0d exp ack=1000 b3=196", bus.ack, bus.balance[3*DW +: DW]); end
        do_bid(4'b0100, 4'b0100, 16'd70);
        checks++; if (bus.ack !== 4'b0100 || bus.balance[2*DW +: DW] !== exp_b2) begin errors++; $display("FAIL bid_and_retract got ack=%b b2=%0d exp ack=0100 b2=%0d", bus.ack, bus.balance[2*DW +: DW], exp_b2); end
        end_round(seen);
        checks++; if (!seen || bus.win !== 4'b0000 || bus.maxBid !== 32'd0 || bus.err !== E_NONE) begin errors++; $display("FAIL retract_round got seen=%b win=%b max=%0d err=%0d exp seen=1 win=0000 max=0 err=0", seen, bus.win, bus.maxBid, bus.err); end
        checks++; if (bus.balance[3*DW +: DW] !== 32'd196) begin errors++; $display("FAIL charge_kept got=%0d exp=196", bus.balance[3*DW +: DW]); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midround();
        tick();
        start_round();
        do_bid(4'b0010, 4'b0000, 16'd5);
        checks++; if (bus.ack !== 4'b0010 || bus.balance[DW +: DW] !== 32'd56) begin errors++; $display("FAIL mid_bid got ack=%b b1=%0d exp ack=0010 b1=56", bus.ack, bus.balance[DW +: DW]); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.balance !== '0 || bus.ready !== 1'b0 || bus.win !== '0) begin errors++; $display("FAIL async_reset got bal=%h ready=%b win=%b exp all 0", bus.balance, bus.ready, bus.win); end
        bus.C_start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bus.ready !== 1'b1 || bus.maxBid !== 32'd0) begin errors++; $display("FAIL post_reset got ready=%b max=%0d exp ready=1 max=0", bus.ready, bus.maxBid); end
        $display("test_reset_midround done");
    endtask

    initial begin
        test_reset();
        test_lock_key();
        test_round_win();
        test_mask();
        test_tie();
        test_back_to_back();
        test_reset_midround();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
